// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and round-robin helper for the SDRAM port arbiter.
package sdram_arb_pkg;
    localparam int MAX_PORTS = 8;
    localparam int ID_W      = 3;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic [ID_W-1:0]  port;
        logic [CNT_W-1:0] remaining;
    } tag_t;

    typedef enum logic {IDLE, WBURST} state_t;

    // First set bit of elig at or after ptr, scanning upward and wrapping at n.
    function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] elig,
                                                 input logic [ID_W-1:0] ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && elig[idx[ID_W-1:0]]) rr_pick = idx[ID_W-1:0];
        end
    endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: in-order read tag FIFO whose head entry can count down beats.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic dec,
    input  tag_t din,
    output tag_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    tag_t       mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Push never targets the head slot while it is live, so both writes can share a cycle.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
        if (dec && !empty) mem[rd_ptr[AW-1:0]].remaining <= mem[rd_ptr[AW-1:0]].remaining - 1'b1;
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: burst-aware round-robin sharing of one SDRAM Avalon-MM port
// among NUM_PORTS masters, with read responses steered back by an in-order tag FIFO.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BURST_W     = 5,
    parameter int MAX_PENDING = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*ADDR_W-1:0]     m_address,
    input  logic [NUM_PORTS-1:0]            m_read,
    input  logic [NUM_PORTS-1:0]            m_write,
    input  logic [NUM_PORTS*DATA_W-1:0]     m_writedata,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   m_byteenable,
    input  logic [NUM_PORTS*BURST_W-1:0]    m_burstcount,
    output logic [NUM_PORTS-1:0]            m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_PORTS-1:0]            m_readdatavalid,
    output logic [ADDR_W-1:0]               s_address,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W-1:0]               s_writedata,
    output logic [DATA_W/8-1:0]             s_byteenable,
    output logic [BURST_W-1:0]              s_burstcount,
    input  logic                            s_waitrequest,
    input  logic [DATA_W-1:0]               s_readdata,
    input  logic                            s_readdatavalid
);
    localparam int BE_W = DATA_W / 8;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr, lock_port, win;
    logic [BURST_W-1:0]   beats_left;
    logic                 err_q;
    logic [NUM_PORTS-1:0] elig;
    logic                 granted, sel_read, sel_write, accept;
    logic                 full, empty, push, pop, dec, head_last;
    tag_t                 head;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) elig[i] = m_write[i] | (m_read[i] & ~full);
    end

    assign win     = (state == WBURST) ? lock_port : rr_pick(MAX_PORTS'(elig), rr_ptr, NUM_PORTS);
    assign granted = reset_n & ((state == WBURST) | (|elig));

    always_comb begin
        sel_read      = 1'b0;
        sel_write     = 1'b0;
        s_address     = '0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_burstcount  = '0;
        m_waitrequest = '1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (granted && win == ID_W'(i)) begin
                sel_read         = m_read[i];
                sel_write        = m_write[i];
                s_address        = m_address[i*ADDR_W +: ADDR_W];
                s_writedata      = m_writedata[i*DATA_W +: DATA_W];
                s_byteenable     = m_byteenable[i*BE_W +: BE_W];
                s_burstcount     = m_burstcount[i*BURST_W +: BURST_W];
                m_waitrequest[i] = s_waitrequest;
            end
        end
    end

    // Mid-burst reads from the locked master are held off until the burst completes.
    assign s_write = sel_write;
    assign s_read  = sel_read & ~sel_write & ~full & (state == IDLE);
    assign accept  = (s_read | s_write) & ~s_waitrequest;

    assign head_last = head.remaining == CNT_W'(1);
    assign push      = accept & s_read;
    assign pop       = s_readdatavalid & ~empty & head_last;
    assign dec       = s_readdatavalid & ~empty & ~head_last;
    assign m_readdata = s_readdata;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            m_readdatavalid[i] = s_readdatavalid & ~empty & (head.port == ID_W'(i));
    end

    sdram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .dec    (dec),
        .din    ('{port: win, remaining: CNT_W'(s_burstcount)}),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_port  <= '0;
            beats_left <= '0;
            err_q      <= 1'b0;
        end else begin
            if (s_readdatavalid && empty) err_q <= 1'b1;
            if (accept) begin
                rr_ptr <= (win == ID_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
                if (state == IDLE && s_write && s_burstcount > BURST_W'(1)) begin
                    state      <= WBURST;
                    lock_port  <= win;
                    beats_left <= s_burstcount - 1'b1;
                end else if (state == WBURST) begin
                    beats_left <= beats_left - 1'b1;
                    if (beats_left == BURST_W'(1)) state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed-vector bench for the SDRAM port arbiter.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] m_address = '0;
    logic [3:0]   m_read = '0;
    logic [3:0]   m_write = '0;
    logic [255:0] m_writedata = '0;
    logic [31:0]  m_byteenable = '0;
    logic [19:0]  m_burstcount = '0;
    logic [3:0]   m_waitrequest;
    logic [63:0]  m_readdata;
    logic [3:0]   m_readdatavalid;
    logic [31:0]  s_address;
    logic         s_read, s_write;
    logic [63:0]  s_writedata;
    logic [7:0]   s_byteenable;
    logic [4:0]   s_burstcount;
    logic         s_waitrequest = 1'b0;
    logic [63:0]  s_readdata = '0;
    logic         s_readdatavalid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    sdram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [4:0] bc);
        m_read[i] = rd;
        m_write[i] = wr;
        m_address[i*32 +: 32] = a;
        m_burstcount[i*5 +: 5] = bc;
        m_writedata[i*64 +: 64] = {32'(i), a};
        m_byteenable[i*8 +: 8] = 8'hFF;
    endtask

    task automatic do_reset();
        m_read = '0;
        m_write = '0;
        s_readdatavalid = 1'b0;
        s_waitrequest = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // reset values
        #1;
        chk("rst_waitreq", 64'(m_waitrequest), 64'hF);
        chk("rst_rdv", 64'(m_readdatavalid), 64'h0);
        chk("rst_s_read", 64'(s_read), 64'h0);
        chk("rst_s_write", 64'(s_write), 64'h0);
        chk("rst_s_bc", 64'(s_burstcount), 64'h0);
        do_reset();

        // single master read burst 4
        set_m(0, 1'b1, 1'b0, 32'h100, 5'd4);
        #1;
        chk("rd4_s_read", 64'(s_read), 64'h1);
        chk("rd4_addr", 64'(s_address), 64'h100);
        chk("rd4_bc", 64'(s_burstcount), 64'h4);
        chk("rd4_waitreq", 64'(m_waitrequest), 64'hE);
        tick();
        m_read[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 64'hA0 + 64'(b);
            #1;
            chk("rd4_rdv", 64'(m_readdatavalid), 64'h1);
            chk("rd4_data", m_readdata, 64'hA0 + 64'(b));
            tick();
        end
        s_readdatavalid = 1'b0;
        #1;
        chk("rd4_empty", 64'(dut.u_fifo.empty), 64'h1);

        // round-robin single writes from all masters
        do_reset();
        for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b1, 32'h1000 * (i + 1), 5'd1);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_waitreq", 64'(m_waitrequest), 64'(~(4'b1 << (k % 4)) & 4'hF));
            chk("rr_s_write", 64'(s_write), 64'h1);
            chk("rr_wdata", s_writedata, {32'(k % 4), 32'h1000 * 32'((k % 4) + 1)});
            tick();
        end
        m_write = '0;

        // master 1 burst 8 holds off master 2; one slave stall mid burst
        do_reset();
        set_m(1, 1'b0, 1'b1, 32'h2000, 5'd8);
        set_m(2, 1'b0, 1'b1, 32'h3000, 5'd1);
        for (int b = 0; b < 9; b++) begin
            s_waitrequest = (b == 2);
            #1;
            chk("wb_waitreq", 64'(m_waitrequest), (b == 2) ? 64'hF : 64'hD);
            if (b == 3) chk("wb_state", 64'(dut.state), 64'(WBURST));
            tick();
        end
        s_waitrequest = 1'b0;
        m_write[1] = 1'b0;
        #1;
        chk("wb_state_idle", 64'(dut.state), 64'(IDLE));
        chk("wb_m2_grant", 64'(m_waitrequest), 64'hB);
        chk("wb_m2_data", s_writedata, {32'd2, 32'h3000});
        tick();
        m_write[2] = 1'b0;

        // fill tag FIFO with 16 reads, then check blocking
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h40, 5'd1);
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k == 15) chk("full_b2b", 64'(m_waitrequest), 64'hE);
            tick();
        end
        chk("full_flag", 64'(dut.u_fifo.full), 64'h1);
        set_m(1, 1'b0, 1'b1, 32'h50, 5'd1);
        #1;
        chk("full_wr_grant", 64'(m_waitrequest), 64'hD);
        chk("full_s_read", 64'(s_read), 64'h0);
        chk("full_s_write", 64'(s_write), 64'h1);
        tick();
        m_write[1] = 1'b0;
        #1;
        chk("full_rd_block", 64'(m_waitrequest), 64'hF);
        s_readdatavalid = 1'b1;
        s_readdata = 64'h55;
        #1;
        chk("full_rsp_rdv", 64'(m_readdatavalid), 64'h1);
        tick();
        s_readdatavalid = 1'b0;
        #1;
        chk("full_rd_freed", 64'(m_waitrequest), 64'hE);
        chk("full_s_read2", 64'(s_read), 64'h1);
        tick();
        m_read[0] = 1'b0;

        // interleaved reads: port 2 burst 2, then port 0 burst 1
        do_reset();
        set_m(2, 1'b1, 1'b0, 32'h200, 5'd2);
        #1;
        chk("il_p2_grant", 64'(m_waitrequest), 64'hB);
        tick();
        m_read[2] = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h300, 5'd1);
        #1;
        chk("il_p0_grant", 64'(m_waitrequest), 64'hE);
        tick();
        m_read[0] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 64'hC0 + 64'(b);
            #1;
            chk("il_rdv", 64'(m_readdatavalid), (b < 2) ? 64'h4 : 64'h1);
            tick();
        end
        s_readdatavalid = 1'b0;
        #1;
        chk("il_empty", 64'(dut.u_fifo.empty), 64'h1);
        chk("il_no_err", 64'(dut.err_q), 64'h0);

        // stray response with FIFO empty
        s_readdatavalid = 1'b1;
        #1;
        chk("err_rdv_drop", 64'(m_readdatavalid), 64'h0);
        tick();
        s_readdatavalid = 1'b0;
        #1;
        chk("err_sticky", 64'(dut.err_q), 64'h1);

        // reset asserted on beat 3 of an 8-beat write burst
        do_reset();
        set_m(3, 1'b0, 1'b1, 32'h400, 5'd8);
        tick();
        tick();
        #1;
        chk("mr_lock", 64'(m_waitrequest), 64'h7);
        reset_n = 1'b0;
        #1;
        chk("mr_waitreq", 64'(m_waitrequest), 64'hF);
        chk("mr_s_write", 64'(s_write), 64'h0);
        chk("mr_s_bc", 64'(s_burstcount), 64'h0);
        chk("mr_state", 64'(dut.state), 64'(IDLE));
        m_write[3] = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_state_post", 64'(dut.state), 64'(IDLE));
        chk("mr_empty", 64'(dut.u_fifo.empty), 64'h1);
        chk("mr_err_clr", 64'(dut.err_q), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one FPGA-to-HPS SDRAM Avalon-MM burst port between NUM_PORTS kernel-side Avalon-MM masters.
- Arbitration is round-robin and burst-aware: a granted write burst keeps the port until its last beat.
- Read responses are routed back to the issuing master through an in-order tag FIFO.
- Sits in the board interface system between the kernel interconnect and the HPS SDRAM controller, in the kernel clock domain.

Parameters:
NUM_PORTS, 4, number of requesting masters (2..8)
ADDR_W, 32, byte address width
DATA_W, 64, data width; byteenable width is DATA_W/8
BURST_W, 5, burstcount width (max burst 2^(BURST_W-1) = 16)
MAX_PENDING, 16, depth of the read tag FIFO (power of 2)

Ports:
clk  in  1  kernel clock; all logic is rising-edge
reset_n  in  1  asynchronous assert, active-low
m_address  in  NUM_PORTS*ADDR_W  per-master address, master i at slice i
m_read  in  NUM_PORTS  per-master read request
m_write  in  NUM_PORTS  per-master write request
m_writedata  in  NUM_PORTS*DATA_W  per-master write data
m_byteenable  in  NUM_PORTS*DATA_W/8  per-master byte enables
m_burstcount  in  NUM_PORTS*BURST_W  per-master burst length
m_waitrequest  out  NUM_PORTS  per-master stall
m_readdata  out  DATA_W  read data, broadcast to all masters
m_readdatavalid  out  NUM_PORTS  one-hot read data valid
s_address  out  ADDR_W  to SDRAM port
s_read  out  1  to SDRAM port
s_write  out  1  to SDRAM port
s_writedata  out  DATA_W  to SDRAM port
s_byteenable  out  DATA_W/8  to SDRAM port
s_burstcount  out  BURST_W  to SDRAM port
s_waitrequest  in  1  from SDRAM port
s_readdata  in  DATA_W  from SDRAM port
s_readdatavalid  in  1  from SDRAM port

Behaviour:
- Reset (reset_n=0, asynchronous) drives state to IDLE and clears the RR pointer and tag FIFO.
- Reset output values: m_waitrequest all 1; m_readdatavalid all 0; s_read=0; s_write=0; s_burstcount=0.
- Masters must hold a request until m_waitrequest[i]=0.
- A master is eligible if read or write is asserted. A read is not eligible while the tag FIFO is full.
- In IDLE, the winner is the first eligible port at or after rr_ptr, scanning upward with wrap.
- The winner's command passes combinationally to s_*; latency is 0 cycles.
- m_waitrequest[winner] = s_waitrequest. All other m_waitrequest bits = 1.
- A transfer is accepted when the s_read or s_write strobe is high and s_waitrequest=0.
- On acceptance, rr_ptr <= winner+1 mod NUM_PORTS.
- Accepted read: push {port id, burstcount} to the tag FIFO. State stays IDLE; a new arbitration happens the next cycle.
- Accepted write, burstcount=1: state stays IDLE.
- Accepted write, burstcount>1: go to WBURST. Latch lock_port and beats_left = burstcount-1.
- In WBURST, only lock_port is connected. s_burstcount is ignored by the slave mid-burst but is driven unchanged.
- In WBURST, each accepted beat decrements beats_left. At 0, return to IDLE.
- In WBURST, read requests from lock_port are not eligible; masters issue a whole burst before reading.
- Response path:
  - On s_readdatavalid, route to the head tag's port: m_readdatavalid[head.port]=1, m_readdata=s_readdata, combinational.
  - Decrement head.remaining. When the last beat arrives, pop the tag.
  - An accept-push and a last-beat pop in the same cycle are both legal; the occupancy count is unchanged.
- Boundaries:
  - FIFO full: read grants are blocked; writes are still granted.
  - s_readdatavalid with the FIFO empty is a protocol error: drop the data, set sticky assertion flag err_q (internal, visible to the bench).
  - The RR pointer wraps NUM_PORTS-1 -> 0.
  - A single requester is granted back-to-back with no bubble cycles.
  - If a reset asserts mid-burst, the tag FIFO is flushed and any in-flight responses are discarded. The system resets the SDRAM port together with this block.
- Arithmetic: beats_left and remaining are BURST_W bits, unsigned. FIFO pointers are log2(MAX_PENDING)+1 bits with a wrap bit.

Decomposition:
- Package sdram_arb_pkg holds:
  - the tag struct {port id [$clog2(NUM_PORTS)-1:0], remaining [BURST_W-1:0]};
  - the state enum {IDLE, WBURST};
  - the function rr_pick(eligible, ptr).
- One sub-module: sdram_arb_tag_fifo, a synchronous FIFO with push/pop/full/empty and a head-entry decrement port.

Test Plan:
- Single master 0, read burst 4, slave waitrequest=0 → s_read on cycle 0; 4 readdata beats arrive → m_readdatavalid=4'b0001 for 4 cycles, FIFO empty afterward.
- Masters 0..3 all issue single writes continuously → grants follow the order 0,1,2,3,0 with no idle cycle; each waitrequest is low exactly once per 4 cycles.
- Master 1 writes burst 8 while master 2 requests → master 2 waitrequest=1 for all 8 beats; master 2 is granted on the cycle after the 8th beat.
- Issue 16 outstanding single reads with no readdatavalid → 17th read is stalled while a write from another port proceeds; one response then frees the read.
- Interleaved reads: port 2 burst 2, then port 0 burst 1 → readdatavalid one-hot is 0100, 0100, 0001.
- Assert reset_n=0 mid write burst (beat 3 of 8) → outputs take reset values immediately; after release, the state is IDLE and the FIFO is empty.
